store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 176 +++++++++++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending word writes, issued in order to the data-memory write port.
// Optional build macro STORE_BUFFER_COALESCE_EN merges stores into the youngest non-issuing entry.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [3:0]    st_byteen,
    input  logic [31:0]   st_wrdata,

    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_byteen,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,

    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [3:0]    ld_byteen,
    output logic          ld_conflict,

    output logic          empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [AW-3:0]  addr_q [DEPTH];
    logic [AW-3:0]  addr_d [DEPTH];
    logic [3:0]     be_q   [DEPTH];
    logic [3:0]     be_d   [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    data_d [DEPTH];

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    logic [0:0]     state_q, state_d;

    logic [PW-1:0]  young_idx;
    logic           merge;
    logic           push;
    logic           pop;
    logic [DEPTH-1:0] vld;

    logic           unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign young_idx = PW'(tail_q - 1'b1);

`ifdef STORE_BUFFER_COALESCE_EN
    // The head is frozen while it is being offered to memory, so it may only merge before issue.
    assign merge = (count_q != '0)
                && (addr_q[young_idx] == st_addr[AW-1:2])
                && (st_byteen != '0)
                && !((state_q == S_REQ) && (young_idx == head_q));
    assign st_ready = (count_q < FULL_CNT) || merge;
`else
    assign merge    = 1'b0;
    assign st_ready = (count_q < FULL_CNT);
`endif

    assign push = st_valid && st_ready && (st_byteen != '0) && !merge;
    assign pop  = (state_q == S_REQ) && mem_ack;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = PW'(tail_q + 1'b1);
        end
        if (pop) begin
            head_d = PW'(head_q + 1'b1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            be_d[i]   = be_q[i];
            data_d[i] = data_q[i];
        end
        if (push) begin
            addr_d[tail_q] = st_addr[AW-1:2];
            be_d[tail_q]   = st_byteen;
            data_d[tail_q] = st_wrdata;
        end
        if (st_valid && merge) begin
            be_d[young_idx] = be_q[young_idx] | st_byteen;
            for (int unsigned b = 0; b < 4; b++) begin
                if (st_byteen[b]) begin
                    data_d[young_idx][8*b +: 8] = st_wrdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pop && (count_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                be_q[i]   <= be_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = mem_req ? {addr_q[head_q], 2'b00} : '0;
    assign mem_byteen = mem_req ? be_q[head_q] : '0;
    assign mem_wdata  = mem_req ? data_q[head_q] : '0;

    // An entry is live when its distance from the head is below the registered count.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            vld[i] = ({1'b0, PW'(PW'(i) - head_q)} < count_q);
        end
    end

    always_comb begin
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i] && (addr_q[i] == ld_addr[AW-1:2]) && ((be_q[i] & ld_byteen) != '0)) begin
                ld_conflict = ld_valid;
            end
        end
    end

    assign empty = (count_q == '0) && !mem_req;

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer, plus a reset-during-request sequence.
module tb_store_buffer;

    logic        clk;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [3:0]  st_byteen;
    logic [31:0] st_wrdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_byteen;
    logic        ld_conflict;
    logic        empty;

    int passed = 0;
    int total  = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_byteen(st_byteen), .st_wrdata(st_wrdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byteen(ld_byteen),
        .ld_conflict(ld_conflict), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [3:0]  sb;
        logic [31:0] sd;
        logic        ack;
        logic        lv;
        logic [31:0] la;
        logic [3:0]  lb;
        logic        e_rdy;
        logic        e_req;
        logic [31:0] e_ma;
        logic [3:0]  e_mb;
        logic [31:0] e_md;
        logic        e_conf;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [3:0] sb,
                                input logic [31:0] sd, input logic ack, input logic lv,
                                input logic [31:0] la, input logic [3:0] lb,
                                input logic rdy, input logic req, input logic [31:0] ma,
                                input logic [3:0] mb, input logic [31:0] md,
                                input logic conf, input logic emp);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sb = sb; v.sd = sd; v.ack = ack;
        v.lv = lv; v.la = la; v.lb = lb;
        v.e_rdy = rdy; v.e_req = req; v.e_ma = ma; v.e_mb = mb; v.e_md = md;
        v.e_conf = conf; v.e_empty = emp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_byteen = '0; st_wrdata = '0;
        mem_ack = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_byteen = '0;
    endtask

    initial begin
        // Single push with ack held, then pop and empty
        vecs.push_back(mk(1,'h10,'hF,'hDEADBEEF,1, 1,'h10,'hF, 1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,'h10,'hF, 1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,1,'h10,'hF,'hDEADBEEF,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,1));
        // Fill to full, held fifth store, order across pointer wrap
        vecs.push_back(mk(1,'h100,'hF,1,0, 0,0,0, 1,0,0,0,0,0,1));
        vecs.push_back(mk(1,'h104,'hF,2,0, 0,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(1,'h108,'hF,3,0, 0,0,0, 1,1,'h100,'hF,1,0,0));
        vecs.push_back(mk(1,'h10C,'hF,4,0, 0,0,0, 1,1,'h100,'hF,1,0,0));
        vecs.push_back(mk(1,'h110,'hF,5,0, 0,0,0, 0,1,'h100,'hF,1,0,0));
        vecs.push_back(mk(1,'h110,'hF,5,1, 0,0,0, 0,1,'h100,'hF,1,0,0));
        vecs.push_back(mk(1,'h110,'hF,5,0, 0,0,0, 1,1,'h104,'hF,2,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 0,1,'h104,'hF,2,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,1,'h108,'hF,3,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,1,'h10C,'hF,4,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,'h110,'h1, 1,1,'h110,'hF,5,1,0));
        vecs.push_back(mk(0,0,0,0,0, 1,'h110,'h1, 1,0,0,0,0,0,1));
        // Load hazard byte-lane overlap
        vecs.push_back(mk(1,'h20,'h3,'h1234,0, 0,0,0, 1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 1,'h22,'hC, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,'h20,'h1, 1,1,'h20,'h3,'h1234,1,0));
        vecs.push_back(mk(0,0,0,0,1, 1,'h24,'hF, 1,1,'h20,'h3,'h1234,0,0));
        vecs.push_back(mk(0,0,0,0,0, 1,'h20,'h1, 1,0,0,0,0,0,1));
        // Zero byte-enable store is discarded
        vecs.push_back(mk(1,'h30,'h0,'h55,0, 0,0,0, 1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 1,'h30,'hF, 1,0,0,0,0,0,1));
        // Same-word stores behind a different head entry
        vecs.push_back(mk(1,'h80,'hF,'h11,0, 0,0,0, 1,0,0,0,0,0,1));
        vecs.push_back(mk(1,'h40,'h1,'hAA,0, 0,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(1,'h40,'h4,'h00BB0000,0, 0,0,0, 1,1,'h80,'hF,'h11,0,0));
        vecs.push_back(mk(0,0,0,0,1, 1,'h40,'h4, 1,1,'h80,'hF,'h11,1,0));
`ifdef STORE_BUFFER_COALESCE_EN
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,1,'h40,'h5,'h00BB00AA,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,0,0,0,0,0,1));
`else
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,1,'h40,'h1,'h000000AA,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,0, 1,1,'h40,'h4,'h00BB0000,0,0));
`endif
        vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,1));

        reset_n = 1'b0;
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 'h10; ld_byteen = 'hF;
        #2;
        chk("reset st_ready", 32'(st_ready), 1);
        chk("reset mem_req", 32'(mem_req), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset ld_conflict", 32'(ld_conflict), 0);
        chk("reset mem_addr", mem_addr, 0);

        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            st_valid = vecs[i].sv; st_addr = vecs[i].sa; st_byteen = vecs[i].sb;
            st_wrdata = vecs[i].sd; mem_ack = vecs[i].ack;
            ld_valid = vecs[i].lv; ld_addr = vecs[i].la; ld_byteen = vecs[i].lb;
            #1;
            chk($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_ma);
            chk($sformatf("v%0d mem_byteen", i), 32'(mem_byteen), 32'(vecs[i].e_mb));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_md);
            chk($sformatf("v%0d ld_conflict", i), 32'(ld_conflict), 32'(vecs[i].e_conf));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
        end

        // Reset asserted mid-cycle while a request with three entries is outstanding
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            st_valid = 1'b1; st_addr = 32'h200 + 32'(4*k); st_byteen = 'hF; st_wrdata = 32'hA0 + 32'(k);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre-reset mem_req", 32'(mem_req), 1);
        chk("pre-reset mem_addr", mem_addr, 'h200);
        chk("pre-reset st_ready", 32'(st_ready), 1);
        #2;
        reset_n = 1'b0;
        ld_valid = 1'b1; ld_addr = 'h204; ld_byteen = 'hF;
        #1;
        chk("async reset mem_req", 32'(mem_req), 0);
        chk("async reset empty", 32'(empty), 1);
        chk("async reset st_ready", 32'(st_ready), 1);
        chk("async reset ld_conflict", 32'(ld_conflict), 0);

        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-reset c%0d mem_req", c), 32'(mem_req), 0);
            chk($sformatf("post-reset c%0d empty", c), 32'(empty), 1);
        end

        @(negedge clk);
        st_valid = 1'b1; st_addr = 'h300; st_byteen = 'hF; st_wrdata = 'hCAFEF00D;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("new push empty", 32'(empty), 0);
        chk("new push mem_req early", 32'(mem_req), 0);
        @(negedge clk);
        #1;
        chk("new push mem_req", 32'(mem_req), 1);
        chk("new push mem_addr", mem_addr, 'h300);
        chk("new push mem_wdata", mem_wdata, 'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("new push drained", 32'(empty), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
